imm_extend_unit: RTL and testbench
==================================

IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 SHALL provide parameter IN_W, default 16, immediate input width (>=2).
REQ-002 SHALL provide parameter OUT_W, default 32, extended output width (OUT_W >= IN_W; elaboration error otherwise).
REQ-003 SHALL provide parameter SHAMT, default 2, left-shift amount for branch-offset mode (0 <= SHAMT < OUT_W).
REQ-004 SHALL provide clk_i  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL provide rst_i  input  1  reset; synchronous and active-high.
REQ-006 SHALL provide valid_i  input  1  upstream request valid.
REQ-007 SHALL provide ready_o  output  1  unit can accept a request this cycle.
REQ-008 SHALL provide data_i  input  IN_W  raw immediate field.
REQ-009 SHALL provide mode_i  input  2  extension mode, sampled with data_i.
REQ-010 SHALL provide valid_o  output  1  extended result available.
REQ-011 SHALL provide ready_i  input  1  downstream accepts result.
REQ-012 SHALL provide data_o  output  OUT_W  extended result at queue head.
REQ-013 SHALL provide mode_o  output  2  mode that produced data_o.

Function
REQ-014 SHALL accept (push) when valid_i && ready_o, and deliver (pop) when valid_o && ready_i.
REQ-015 SHALL compute the extension combinationally on data_i/mode_i at push and store the OUT_W result plus mode in a 2-entry in-order queue.
REQ-016 Mode 00 (SEXT): data_i[IN_W-1] replicated into bits OUT_W-1..IN_W, low IN_W bits = data_i.
REQ-017 Mode 01 (ZEXT): bits OUT_W-1..IN_W = 0, low bits = data_i.
REQ-018 Mode 10 (UPPER): bits OUT_W-1..OUT_W-IN_W = data_i, remaining low bits = 0.
REQ-019 Mode 11 (BOFS): SEXT result shifted left SHAMT, zeros shifted in, upper bits discarded (truncate to OUT_W).
REQ-020 Latency: result pushed in cycle N SHALL be visible on data_o/valid_o in cycle N+1 at earliest; no combinational path data_i->data_o.
REQ-021 valid_o SHALL equal (count != 0); ready_o SHALL equal (count != 2); both derived only from registered count.
REQ-022 Count 0: push only -> count 1.
REQ-023 Count 1: push and pop same cycle -> count stays 1, new entry becomes head next cycle; push only -> 2; pop only -> 0.
REQ-024 Count 2 (full): ready_o=0, valid_i ignored, no data lost; pop -> count 1.
REQ-025 data_o/mode_o SHALL hold stable while valid_o && !ready_i.
REQ-026 Pointers SHALL wrap modulo 2; order of delivery SHALL equal order of acceptance.
REQ-027 When count=0, data_o and mode_o SHALL be 0.

Reset
REQ-028 On rst_i=1 at a clock edge: count=0, pointers=0, storage cleared; next cycle valid_o=0, ready_o=1, data_o=0, mode_o=0.
REQ-029 Reset SHALL override simultaneous push/pop; queued entries discarded (reset mid-operation drops in-flight data).

Structure
REQ-030 Mode encodings (MODE_SEXT=00, MODE_ZEXT=01, MODE_UPPER=10, MODE_BOFS=11) SHALL live in shared package imm_ext_pkg.
REQ-031 Combinational extension SHALL be sub-module imm_ext_core (params IN_W, OUT_W, SHAMT); queue/handshake in imm_extend_unit.

Verification (defaults IN_W=16, OUT_W=32, SHAMT=2, ready_i=1 unless stated)
REQ-032 Push 0x8001 mode 00 -> next cycle valid_o=1, data_o=0xFFFF8001; mode 01 -> 0x00008001.
REQ-033 Push 0x1234 mode 10 -> 0x12340000; push 0xFFFF mode 11 -> 0xFFFFFFFC; push 0x4000 mode 11 -> 0x00010000.
REQ-034 ready_i=0, push A=0x0001, B=0x0002, C=0x0003 on consecutive cycles -> ready_o=0 after B, C not accepted; ready_i=1 -> A then B delivered, data_o stable while stalled.
REQ-035 Count 1, push and pop same cycle for 10 cycles -> one result per cycle, count stays 1, no drops/duplicates.
REQ-036 Count 2, assert rst_i one cycle with valid_i=1 -> next cycle valid_o=0, ready_o=1, data_o=0, no entry retained.
REQ-037 Parameter sweep IN_W=12, OUT_W=16: push 0x800 mode 00 -> 0xF800; mode 10 -> 0x8000.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared extension-mode encodings for the immediate extend unit
package imm_ext_pkg;
  typedef enum logic [1:0] {
    MODE_SEXT  = 2'b00,
    MODE_ZEXT  = 2'b01,
    MODE_UPPER = 2'b10,
    MODE_BOFS  = 2'b11
  } mode_e;
endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extension (data_i, mode_i -> ext_o; SEXT/ZEXT/UPPER/BOFS)
module imm_ext_core import imm_ext_pkg::*; #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] ext_o
);
  if (IN_W < 2) begin : g_in_w_err
    $error("imm_ext_core: IN_W must be >= 2");
  end
  if (OUT_W < IN_W) begin : g_out_w_err
    $error("imm_ext_core: OUT_W must be >= IN_W");
  end
  if (SHAMT < 0 || SHAMT >= OUT_W) begin : g_shamt_err
    $error("imm_ext_core: SHAMT out of range");
  end
  logic [OUT_W-1:0] sext, zext, upper, bofs;
  assign sext  = OUT_W'($signed(data_i));
  assign zext  = OUT_W'(data_i);
  assign upper = zext << (OUT_W - IN_W);
  assign bofs  = sext << SHAMT;
  always_comb begin
    ext_o = mode_i == MODE_SEXT  ? sext  :
            mode_i == MODE_ZEXT  ? zext  :
            mode_i == MODE_UPPER ? upper : bofs;
  end
endmodule

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: valid/ready immediate extender (in: clk_i rst_i valid_i data_i mode_i ready_i; out: ready_o valid_o data_o mode_o) with 2-entry in-order result queue
module imm_extend_unit import imm_ext_pkg::*; #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] data_o,
  output logic [1:0]       mode_o
);
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] data_q [2];
  logic [1:0]       mode_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;
  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT(SHAMT)) u_core (
    .data_i(data_i),
    .mode_i(mode_i),
    .ext_o (ext)
  );
  assign valid_o = cnt_q != 2'd0;
  assign ready_o = cnt_q != 2'd2;
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;
  assign data_o  = valid_o ? data_q[rd_ptr_q] : '0;
  assign mode_o  = valid_o ? mode_q[rd_ptr_q] : '0;
  always_comb begin
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q   <= '{default: '0};
      mode_q   <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= ext;
        mode_q[wr_ptr_q] <= mode_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: directed self-checking bench for imm_extend_unit (default and 12/16 configurations)
module tb_imm_extend_unit;
  import imm_ext_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_i, ready_o, valid_o;
  logic [15:0] data_i;
  logic [1:0]  mode_i, mode_o;
  logic [31:0] data_o;
  logic        valid_b_i, ready_b_i, ready_b_o, valid_b_o;
  logic [11:0] data_b_i;
  logic [1:0]  mode_b_i, mode_b_o;
  logic [15:0] data_b_o;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  imm_extend_unit dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .mode_i(mode_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .mode_o(mode_o)
  );
  imm_extend_unit #(.IN_W(12), .OUT_W(16), .SHAMT(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_b_i), .ready_o(ready_b_o),
    .data_i(data_b_i), .mode_i(mode_b_i), .valid_o(valid_b_o), .ready_i(ready_b_i),
    .data_o(data_b_o), .mode_o(mode_b_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; data_i = '0; mode_i = '0;
    valid_b_i = 1'b0; ready_b_i = 1'b1; data_b_i = '0; mode_b_i = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_data", data_o, 0);
    chk("rst_mode", mode_o, 0);
    valid_i = 1'b1; data_i = 16'h8001; mode_i = MODE_SEXT;
    tick();
    chk("sext_valid", valid_o, 1);
    chk("sext_data", data_o, 32'hFFFF8001);
    chk("sext_mode", mode_o, 0);
    data_i = 16'h8001; mode_i = MODE_ZEXT;
    tick();
    chk("zext_data", data_o, 32'h00008001);
    chk("zext_mode", mode_o, 1);
    data_i = 16'h1234; mode_i = MODE_UPPER;
    tick();
    chk("upper_data", data_o, 32'h12340000);
    chk("upper_mode", mode_o, 2);
    data_i = 16'hFFFF; mode_i = MODE_BOFS;
    tick();
    chk("bofs_neg", data_o, 32'hFFFFFFFC);
    data_i = 16'h4000; mode_i = MODE_BOFS;
    tick();
    chk("bofs_pos", data_o, 32'h00010000);
    chk("bofs_mode", mode_o, 3);
    data_i = 16'h1234; mode_i = MODE_SEXT;
    tick();
    chk("sext_pos", data_o, 32'h00001234);
    valid_i = 1'b0;
    tick();
    chk("empty_valid", valid_o, 0);
    chk("empty_data", data_o, 0);
    chk("empty_mode", mode_o, 0);
    ready_i = 1'b0; valid_i = 1'b1; mode_i = MODE_ZEXT; data_i = 16'h0001;
    tick();
    chk("stall_a_ready", ready_o, 1);
    chk("stall_a_data", data_o, 32'h1);
    data_i = 16'h0002;
    tick();
    chk("full_ready", ready_o, 0);
    chk("full_valid", valid_o, 1);
    data_i = 16'h0003;
    tick();
    chk("full_c_ready", ready_o, 0);
    chk("stall_hold1", data_o, 32'h1);
    valid_i = 1'b0;
    tick();
    chk("stall_hold2", data_o, 32'h1);
    ready_i = 1'b1;
    tick();
    chk("drain_b", data_o, 32'h2);
    chk("drain_ready", ready_o, 1);
    tick();
    chk("drain_empty", valid_o, 0);
    valid_i = 1'b1; data_i = 16'h0100; mode_i = MODE_ZEXT;
    tick();
    chk("stream_first", data_o, 32'h100);
    for (int i = 1; i <= 10; i++) begin
      data_i = 16'h0100 + 16'(i);
      tick();
      chk("stream_data", data_o, 32'h100 + 32'(i));
      chk("stream_ready", ready_o, 1);
    end
    valid_i = 1'b0;
    tick();
    chk("stream_end", valid_o, 0);
    ready_i = 1'b0; valid_i = 1'b1; data_i = 16'hAAAA;
    tick();
    data_i = 16'hBBBB;
    tick();
    chk("pre_rst_full", ready_o, 0);
    rst = 1'b1; data_i = 16'hCCCC;
    tick();
    rst = 1'b0; valid_i = 1'b0;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_mode", mode_o, 0);
    ready_i = 1'b1;
    tick();
    chk("mid_rst_retained", valid_o, 0);
    valid_b_i = 1'b1; data_b_i = 12'h800; mode_b_i = MODE_SEXT;
    tick();
    chk("p_sext", data_b_o, 32'hF800);
    mode_b_i = MODE_UPPER;
    tick();
    chk("p_upper", data_b_o, 32'h8000);
    mode_b_i = MODE_ZEXT;
    tick();
    chk("p_zext", data_b_o, 32'h0800);
    mode_b_i = MODE_BOFS;
    tick();
    chk("p_bofs", data_b_o, 32'hE000);
    valid_b_i = 1'b0;
    tick();
    chk("p_empty", valid_b_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
